// File: rtl/regbank_pkg.sv
// Shared types and helpers for the parametrised register bank.
// Holds the clear-sequencer state enum and the byte-merge helper used by the write path and bypass.
package regbank_pkg;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_CLEAR
  } clr_state_t;

  // Widest entry the merge helper supports; callers size-cast in and out.
  localparam int REGBANK_MAX_W  = 1024;
  localparam int REGBANK_MAX_BE = REGBANK_MAX_W / 8;

  function automatic logic [REGBANK_MAX_W-1:0] byte_merge(
    input logic [REGBANK_MAX_W-1:0]  old_v,
    input logic [REGBANK_MAX_W-1:0]  new_v,
    input logic [REGBANK_MAX_BE-1:0] be
  );
    logic [REGBANK_MAX_W-1:0] merged;
    merged = old_v;
    for (int i = 0; i < REGBANK_MAX_BE; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_v[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/regbank_clear_fsm.sv
// Sweep-clear sequencer: walks every entry index once, one per cycle, while busy is high.
module regbank_clear_fsm
  import regbank_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  clr_state_t        r_state;
  clr_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] w_count_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // clr_req is only looked at in IDLE, so a held request re-arms after each sweep.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    busy        = 1'b0;
    clr_we      = 1'b0;
    clr_addr    = r_count;
    case (r_state)
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_count_nxt = '0;
        end
      end
      ST_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (r_count == LAST_IDX) begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = '0;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

endmodule

// File: rtl/param_regbank.sv
// Parametrised register bank: two registered read ports, one byte-enabled write port, sweep clear.
// Define REGBANK_BYPASS_EN to forward a same-edge write into a read of the same address.
module param_regbank
  import regbank_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [ADDR_W-1:0]   wa,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                re,
  input  logic [ADDR_W-1:0]   ra1,
  input  logic [ADDR_W-1:0]   ra2,
  output logic [DATA_W-1:0]   rdata1,
  output logic [DATA_W-1:0]   rdata2,
  output logic                rvalid,
  input  logic                clr_req,
  output logic                busy,
  output logic                addr_err
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata1;
  logic [DATA_W-1:0] r_rdata2;
  logic              r_rvalid;
  logic              r_addr_err;

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wa_ok;
  logic              w_ra1_ok;
  logic              w_ra2_ok;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_err;
  logic [DATA_W-1:0] w_wr_old;
  logic [DATA_W-1:0] w_wr_merged;
  logic [DATA_W-1:0] w_rd1_val;
  logic [DATA_W-1:0] w_rd2_val;

  regbank_clear_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (w_busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  // A power-of-two depth leaves no unused codes, so range checks collapse to constants.
  if (DEPTH == (1 << ADDR_W)) begin : g_full_range
    assign w_wa_ok  = 1'b1;
    assign w_ra1_ok = 1'b1;
    assign w_ra2_ok = 1'b1;
  end else begin : g_partial_range
    assign w_wa_ok  = (wa  < ADDR_W'(DEPTH));
    assign w_ra1_ok = (ra1 < ADDR_W'(DEPTH));
    assign w_ra2_ok = (ra2 < ADDR_W'(DEPTH));
  end

  assign w_wr_acc = !w_busy && we && w_wa_ok && !((ZERO_REG != 0) && (wa == '0));
  assign w_rd_acc = !w_busy && re;
  assign w_err    = !w_busy && ((we && !w_wa_ok) || (re && (!w_ra1_ok || !w_ra2_ok)));

  assign w_wr_old    = w_wa_ok ? r_mem[wa] : '0;
  assign w_wr_merged = DATA_W'(byte_merge(REGBANK_MAX_W'(w_wr_old),
                                          REGBANK_MAX_W'(wdata),
                                          REGBANK_MAX_BE'(wbe)));

  always_comb begin
    w_rd1_val = '0;
    w_rd2_val = '0;
    if (w_ra1_ok && !((ZERO_REG != 0) && (ra1 == '0))) begin
      w_rd1_val = r_mem[ra1];
`ifdef REGBANK_BYPASS_EN
      if (w_wr_acc && (wa == ra1)) begin
        w_rd1_val = w_wr_merged;
      end
`endif
    end
    if (w_ra2_ok && !((ZERO_REG != 0) && (ra2 == '0))) begin
      w_rd2_val = r_mem[ra2];
`ifdef REGBANK_BYPASS_EN
      if (w_wr_acc && (wa == ra2)) begin
        w_rd2_val = w_wr_merged;
      end
`endif
    end
  end

  // The sweep owns the array while busy; user writes are only accepted outside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_acc) begin
      r_mem[wa] <= w_wr_merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata1   <= '0;
      r_rdata2   <= '0;
      r_rvalid   <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_rvalid   <= w_rd_acc;
      r_addr_err <= w_err;
      if (w_rd_acc) begin
        r_rdata1 <= w_rd1_val;
        r_rdata2 <= w_rd2_val;
      end
    end
  end

  assign rdata1   = r_rdata1;
  assign rdata2   = r_rdata2;
  assign rvalid   = r_rvalid;
  assign busy     = w_busy;
  assign addr_err = r_addr_err;

endmodule

// File: tb/tb_param_regbank.sv
// Bench for param_regbank: bank A (DEPTH=5) and bank B (DEPTH=8, ZERO_REG=1) share one stimulus stream.
module tb_param_regbank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [2:0]  wa;
  logic [3:0]  wbe;
  logic [31:0] wdata;
  logic        re;
  logic [2:0]  ra1;
  logic [2:0]  ra2;
  logic        clr_req;

  logic [31:0] rdA1, rdA2, rdB1, rdB2;
  logic        rvA, rvB, busyA, busyB, errA, errB;

  param_regbank #(.DATA_W(32), .DEPTH(5), .ZERO_REG(0)) dutA (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wbe(wbe), .wdata(wdata),
    .re(re), .ra1(ra1), .ra2(ra2), .rdata1(rdA1), .rdata2(rdA2), .rvalid(rvA),
    .clr_req(clr_req), .busy(busyA), .addr_err(errA)
  );

  param_regbank #(.DATA_W(32), .DEPTH(8), .ZERO_REG(1)) dutB (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wbe(wbe), .wdata(wdata),
    .re(re), .ra1(ra1), .ra2(ra2), .rdata1(rdB1), .rdata2(rdB2), .rvalid(rvB),
    .clr_req(clr_req), .busy(busyB), .addr_err(errB)
  );

  always #5 clk = ~clk;

`ifdef REGBANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
  localparam logic [31:0] BYP4 = 32'hDEADBEEF;
`else
  localparam bit BYPASS = 1'b0;
  localparam logic [31:0] BYP4 = 32'h0;
`endif

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [3:0]  wbe;
    logic [31:0] wdata;
    logic        re;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic        clr;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        erv;
    logic        eerr;
    logic        ebusy;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: plain arrays per bank, sweep tracked as cycles remaining.
  logic [31:0] mMem [2][8];
  int          mLeft [2];
  logic [31:0] mRd1 [2];
  logic [31:0] mRd2 [2];
  logic        mRv [2];
  logic        mErr [2];

  function automatic int depthOf(int b);
    return (b == 0) ? 5 : 8;
  endfunction

  function automatic logic [31:0] mergeBytes(logic [31:0] o, logic [31:0] n, logic [3:0] be);
    logic [31:0] mask;
    mask = 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
    return (o & ~mask) | (n & mask);
  endfunction

  function automatic logic [31:0] readVal(int b, logic [2:0] a, bit wacc, logic [31:0] merged);
    if (int'(a) >= depthOf(b)) return 32'h0;
    if (b == 1 && a == 3'd0) return 32'h0;
    if (BYPASS && wacc && a == wa) return merged;
    return mMem[b][a];
  endfunction

  task automatic modelReset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 8; i++) mMem[b][i] = 32'h0;
      mLeft[b] = 0;
      mRd1[b]  = 32'h0;
      mRd2[b]  = 32'h0;
      mRv[b]   = 1'b0;
      mErr[b]  = 1'b0;
    end
  endtask

  task automatic modelStep();
    for (int b = 0; b < 2; b++) begin
      int dep;
      bit wacc;
      logic [31:0] merged;
      dep = depthOf(b);
      if (mLeft[b] > 0) begin
        mMem[b][dep - mLeft[b]] = 32'h0;
        mLeft[b] = mLeft[b] - 1;
        mRv[b]  = 1'b0;
        mErr[b] = 1'b0;
      end else begin
        wacc   = we && (int'(wa) < dep) && !(b == 1 && wa == 3'd0);
        merged = mergeBytes(mMem[b][wa], wdata, wbe);
        mErr[b] = (we && int'(wa) >= dep) || (re && (int'(ra1) >= dep || int'(ra2) >= dep));
        mRv[b]  = re;
        if (re) begin
          mRd1[b] = readVal(b, ra1, wacc, merged);
          mRd2[b] = readVal(b, ra2, wacc, merged);
        end
        if (wacc) mMem[b][wa] = merged;
        if (clr_req) mLeft[b] = dep;
      end
    end
  endtask

  task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkBank(string tag, int b, logic [31:0] r1, logic [31:0] r2,
                           logic rv, logic bs, logic er);
    checkVal($sformatf("%s.rdata1@%0d", tag, cyc), r1, mRd1[b]);
    checkVal($sformatf("%s.rdata2@%0d", tag, cyc), r2, mRd2[b]);
    checkVal($sformatf("%s.rvalid@%0d", tag, cyc), {31'b0, rv}, {31'b0, mRv[b]});
    checkVal($sformatf("%s.busy@%0d", tag, cyc), {31'b0, bs}, {31'b0, (mLeft[b] > 0)});
    checkVal($sformatf("%s.addr_err@%0d", tag, cyc), {31'b0, er}, {31'b0, mErr[b]});
  endtask

  task automatic checkOutput();
    checkBank("A", 0, rdA1, rdA2, rvA, busyA, errA);
    checkBank("B", 1, rdB1, rdB2, rvB, busyB, errB);
  endtask

  task automatic applyStimulus(vec_t v);
    we = v.we; wa = v.wa; wbe = v.wbe; wdata = v.wdata;
    re = v.re; ra1 = v.ra1; ra2 = v.ra2; clr_req = v.clr;
  endtask

  task automatic setIdle();
    we = 0; wa = 0; wbe = 0; wdata = 0; re = 0; ra1 = 0; ra2 = 0; clr_req = 0;
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
    cyc++;
    checkOutput();
  endtask

  task automatic drain();
    setIdle();
    for (int i = 0; i < 20 && (mLeft[0] > 0 || mLeft[1] > 0); i++) tick();
    checkVal("drain.timeout", {31'b0, (mLeft[0] > 0 || mLeft[1] > 0)}, 32'h0);
  endtask

  function automatic vec_t mk(int unsigned we_, int unsigned wa_, int unsigned wbe_,
                              int unsigned wd_, int unsigned re_, int unsigned r1_,
                              int unsigned r2_, int unsigned clr_, int unsigned e1_,
                              int unsigned e2_, int unsigned erv_, int unsigned eerr_,
                              int unsigned ebusy_);
    vec_t v;
    v.we = 1'(we_); v.wa = 3'(wa_); v.wbe = 4'(wbe_); v.wdata = 32'(wd_);
    v.re = 1'(re_); v.ra1 = 3'(r1_); v.ra2 = 3'(r2_); v.clr = 1'(clr_);
    v.e1 = 32'(e1_); v.e2 = 32'(e2_); v.erv = 1'(erv_); v.eerr = 1'(eerr_);
    v.ebusy = 1'(ebusy_);
    return v;
  endfunction

  vec_t tbl [20];

  initial begin
    // Directed sequence; expected columns are bank A's outputs after each edge.
    tbl[0]  = mk(0,0,0,0,                  1,0,3,0, 0,0,1,0,0);
    tbl[1]  = mk(1,2,4'hF,32'hAABBCCDD,    0,0,0,0, 0,0,0,0,0);
    tbl[2]  = mk(1,2,4'h5,32'h11223344,    0,0,0,0, 0,0,0,0,0);
    tbl[3]  = mk(0,0,0,0,                  1,2,2,0, 32'hAA22CC44,32'hAA22CC44,1,0,0);
    tbl[4]  = mk(1,1,4'hF,32'hDEADBEEF,    1,1,2,0, BYP4,32'hAA22CC44,1,0,0);
    tbl[5]  = mk(0,0,0,0,                  1,1,0,0, 32'hDEADBEEF,0,1,0,0);
    tbl[6]  = mk(1,6,4'hF,32'h12345678,    0,0,0,0, 32'hDEADBEEF,0,0,1,0);
    tbl[7]  = mk(0,0,0,0,                  1,2,2,0, 32'hAA22CC44,32'hAA22CC44,1,0,0);
    tbl[8]  = mk(0,0,0,0,                  1,2,7,0, 32'hAA22CC44,0,1,1,0);
    tbl[9]  = mk(0,0,0,0,                  0,0,0,0, 32'hAA22CC44,0,0,0,0);
    tbl[10] = mk(0,0,0,0,                  1,5,1,0, 0,32'hDEADBEEF,1,1,0);
    tbl[11] = mk(1,3,4'hF,32'hFFFFFFFF,    1,2,1,1, 32'hAA22CC44,32'hDEADBEEF,1,0,1);
    tbl[12] = mk(1,4,4'hF,32'hFFFFFFFF,    1,7,3,0, 32'hAA22CC44,32'hDEADBEEF,0,0,1);
    tbl[13] = mk(0,0,0,0,                  0,0,0,0, 32'hAA22CC44,32'hDEADBEEF,0,0,1);
    tbl[14] = mk(0,0,0,0,                  0,0,0,0, 32'hAA22CC44,32'hDEADBEEF,0,0,1);
    tbl[15] = mk(0,0,0,0,                  0,0,0,0, 32'hAA22CC44,32'hDEADBEEF,0,0,1);
    tbl[16] = mk(1,0,4'hF,32'hFFFFFFFF,    1,0,0,0, 32'hAA22CC44,32'hDEADBEEF,0,0,0);
    tbl[17] = mk(0,0,0,0,                  1,3,4,0, 0,0,1,0,0);
    tbl[18] = mk(0,0,0,0,                  1,1,2,0, 0,0,1,0,0);
    tbl[19] = mk(0,0,0,0,                  1,0,0,0, 0,0,1,0,0);

    rst_n = 1'b0;
    setIdle();
    modelReset();
    #1;
    checkOutput();
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      applyStimulus(tbl[i]);
      tick();
      checkVal($sformatf("tbl%0d.rdata1", i), rdA1, tbl[i].e1);
      checkVal($sformatf("tbl%0d.rdata2", i), rdA2, tbl[i].e2);
      checkVal($sformatf("tbl%0d.rvalid", i), {31'b0, rvA}, {31'b0, tbl[i].erv});
      checkVal($sformatf("tbl%0d.addr_err", i), {31'b0, errA}, {31'b0, tbl[i].eerr});
      checkVal($sformatf("tbl%0d.busy", i), {31'b0, busyA}, {31'b0, tbl[i].ebusy});
    end
    drain();

    // Hard-wired zero entry: bank B drops the write silently, bank A keeps it.
    setIdle();
    we = 1; wa = 0; wbe = 4'hF; wdata = 32'h5;
    tick();
    checkVal("zero.write_err", {31'b0, errB}, 32'h0);
    setIdle();
    re = 1; ra1 = 0; ra2 = 0;
    tick();
    checkVal("zero.B_rdata1", rdB1, 32'h0);
    checkVal("zero.A_rdata1", rdA1, 32'h5);
    checkVal("zero.B_err", {31'b0, errB}, 32'h0);

    // Held clr_req re-arms the sweep right after each pass.
    for (int i = 0; i < 20; i++) begin
      we = 1'($urandom_range(0, 1)); wa = 3'($urandom_range(0, 7));
      wbe = 4'($urandom); wdata = $urandom;
      re = 1'($urandom_range(0, 1)); ra1 = 3'($urandom_range(0, 7)); ra2 = 3'($urandom_range(0, 7));
      clr_req = 1'b1;
      tick();
    end
    drain();

    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom_range(0, 1)); wa = 3'($urandom_range(0, 7));
      wbe = 4'($urandom); wdata = $urandom;
      re = 1'($urandom_range(0, 1)); ra1 = 3'($urandom_range(0, 7)); ra2 = 3'($urandom_range(0, 7));
      clr_req = 1'($urandom_range(0, 29) == 0);
      tick();
    end
    drain();

    // Fill everything, start a sweep, and pull reset two sweep edges in.
    for (int a = 0; a < 8; a++) begin
      setIdle();
      we = 1; wa = 3'(a); wbe = 4'hF; wdata = 32'hFFFFFFFF;
      tick();
    end
    setIdle();
    clr_req = 1;
    tick();
    setIdle();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    checkVal("midreset.busyB", {31'b0, busyB}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      setIdle();
      re = 1; ra1 = 3'(a); ra2 = 3'(7 - a);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/param_regbank.md
# param_regbank

Parametrised multi-entry register bank with two synchronous read ports, one byte-enabled write port, and a hardware clear sequencer. It replaces the fixed 4x32 bank in datapath designs. It adds:
- configurable width and depth
- registered reads with a valid strobe
- an optional hard-wired zero entry
- address-range checking
- a sweep-clear operation usable at run time

## Interface
- DATA_W, 32, entry width in bits; must be a multiple of 8
- DEPTH, 4, number of entries, >= 2, need not be a power of two
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)
- ZERO_REG, 0, when 1 entry 0 always reads zero and ignores writes

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- we  in  1  write enable
- wa  in  ADDR_W  write address
- wbe  in  DATA_W/8  byte enables for the write
- wdata  in  DATA_W  write data
- re  in  1  read enable, both ports
- ra1, ra2  in  ADDR_W  read addresses
- rdata1, rdata2  out  DATA_W  registered read data
- rvalid  out  1  rdata1/rdata2 updated this cycle
- clr_req  in  1  start sweep clear (level sampled)
- busy  out  1  clear sweep in progress
- addr_err  out  1  one-cycle pulse: out-of-range access attempted

## Operation
- **Reset:** all entries, rdata1, rdata2, rvalid, busy and addr_err go to 0. The FSM goes to IDLE.
- **Write:** on an edge with we=1 in IDLE and wa<DEPTH, each byte i of entry wa with wbe[i]=1 takes wdata byte i. Other bytes hold.
  - wa>=DEPTH: write dropped, addr_err pulses.
  - ZERO_REG=1 and wa=0: write dropped silently (no error).
- **Read:** on an edge with re=1 in IDLE, rdata1 and rdata2 capture entry[ra1] and entry[ra2]; rvalid=1 in the following cycle.
  - An out-of-range address returns 0 on that port and pulses addr_err.
  - Entry 0 returns 0 when ZERO_REG=1.
  - With re=0, rdata holds its last value and rvalid=0.
- **Same-edge write and read to one address:** the read returns the pre-write contents, unless REGBANK_BYPASS_EN is defined (see Configuration).
- **Clear FSM, states IDLE and CLEAR:**
  - IDLE: clr_req=1 moves to CLEAR with the sweep counter at 0.
  - CLEAR: each cycle, entry[counter] is zeroed and the counter increments. When the counter reaches DEPTH-1, that entry is zeroed and the FSM returns to IDLE.
  - busy=1 throughout CLEAR.
  - During CLEAR, we and re are ignored (no addr_err, rvalid=0), and clr_req is ignored.
  - Holding clr_req high re-triggers a clear on the cycle after returning to IDLE.
- **Simultaneous clr_req and we/re in IDLE:** that edge's write and read complete normally, and the clear starts on the same edge.
- **Reset asserted mid-sweep:** immediate return to IDLE, all entries 0, busy=0.

## Timing
- Write visible to a read issued on the next edge (1-cycle write-to-read).
- Read latency 1 cycle: address sampled at edge N, rdata and rvalid valid after edge N.
- Clear takes exactly DEPTH cycles.
  - busy rises after the edge that samples clr_req and falls after the DEPTH-th sweep edge.
  - The first accepted we/re is on the edge where busy=0 again.
- addr_err is registered and asserts in the cycle after the offending edge, for exactly one cycle.

## Configuration
- **REGBANK_BYPASS_EN defined:** a read on the same edge as an accepted write to the same in-range address returns the merged value. Bytes with wbe=1 come from wdata, the rest from the old entry. Bypass is per port, and ZERO_REG still forces 0.
- **Undefined:** no forwarding; a same-address read returns old contents.

## Structure
- Shared package regbank_pkg holds:
  - the FSM state enum (ST_IDLE, ST_CLEAR)
  - a byte-merge function (old, new, be) used by the write path and bypass
- Sub-module regbank_clear_fsm holds the state register and sweep counter. Its outputs are busy, clr_we and clr_addr. The top holds the storage array, read registers and error logic.

## Test plan
- **Reset then read:** after reset, re=1 with ra1=0, ra2=3 -> rvalid=1 next cycle, rdata1=rdata2=0.
- **Byte-enable write:** write 0xAABBCCDD to entry 2 with wbe=4'hF, then 0x11223344 with wbe=4'b0101 -> read of entry 2 gives 0xAA22CC44.
- **Same-edge write and read:** write 0xDEADBEEF to entry 1 while reading ra1=1. Old value 0x0 -> rdata1=0x0 without REGBANK_BYPASS_EN, 0xDEADBEEF with it.
- **Out-of-range access:** DEPTH=5, we=1 with wa=6 -> addr_err pulses one cycle and no entry changes. re with ra2=7 -> rdata2=0 and addr_err pulses.
- **Sweep clear:** fill all entries with 0xFFFFFFFF, pulse clr_req -> busy high exactly DEPTH cycles. A write issued during busy is ignored, and all entries read 0 afterward.
- **Reset mid-sweep:** assert rst_n=0 at sweep cycle 2 of DEPTH=8 -> busy=0 immediately and all entries read 0. ZERO_REG=1 run: write 0x5 to entry 0 -> reads 0, no addr_err.
